lmmi_arbiter: RTL

// - Shares one LMMI target (e.g. a hard-IP config port) between NUM_REQ Wishbone requesters.
// - Round-robin arbitration; one LMMI transaction in flight at a time.
// - Sits between CPU/DMA Wishbone masters and the LMMI-attached IP. Replaces per-master WB-to-LMMI bridges.

---
 rtl/lmmi_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lmmi_arbiter.sv
// lmmi_arbiter: round-robin share of one LMMI target among NUM_REQ Wishbone requesters.
// Define LMMI_ARB_TIMEOUT_EN to bound REQ/RDWAIT by TIMEOUT_CYCLES and answer with wb_err.
module lmmi_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    wb_cyc,
  input  logic [NUM_REQ-1:0]    wb_stb,
  input  logic [NUM_REQ-1:0]    wb_we,
  input  logic [NUM_REQ*18-1:0] wb_adr,
  input  logic [NUM_REQ*32-1:0] wb_dat_w,
  output logic [NUM_REQ-1:0]    wb_ack,
  output logic [NUM_REQ-1:0]    wb_err,
  output logic [NUM_REQ*32-1:0] wb_dat_r,
  output logic                  lmmi_request,
  output logic                  lmmi_wr_rdn,
  output logic [15:0]           lmmi_offset,
  output logic [31:0]           lmmi_wdata,
  input  logic                  lmmi_ready,
  input  logic [31:0]           lmmi_rdata,
  input  logic                  lmmi_rdata_valid
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [2:0] {IDLE, REQ, RDWAIT, ACK, ERR} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, nxt;
  logic [15:0] offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, dat_g;
  logic wr_q, wr_d, abort_q, abort_d, found, we_g, cyc_g, timeout;
  logic [17:0] adr_g;
  logic [NUM_REQ-1:0] pending;
  logic unused_adr;
  assign pending = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
  assign unused_adr = ^adr_g[1:0];
  assign lmmi_request = state_q == REQ;
  assign lmmi_wr_rdn = wr_q;
  assign lmmi_offset = offset_q;
  assign lmmi_wdata = wdata_q;
  // Scan requesters starting just after last_q so every index gets a turn.
  always_comb begin
    found = 1'b0;
    nxt = '0;
    adr_g = '0;
    dat_g = '0;
    we_g = 1'b0;
    cyc_g = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (!found && pending[i] && i == (int'(last_q) + k) % NUM_REQ) begin
          found = 1'b1;
          nxt = GW'(i);
          adr_g = wb_adr[18*i +: 18];
          dat_g = wb_dat_w[32*i +: 32];
          we_g = wb_we[i];
        end
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q == GW'(i)) cyc_g = wb_cyc[i];
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    offset_d = offset_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    rdata_d = rdata_q;
    abort_d = abort_q | (state_q != IDLE && !cyc_g);
    case (state_q)
      IDLE: if (found) begin
        state_d = REQ;
        grant_d = nxt;
        offset_d = adr_g[17:2];
        wdata_d = dat_g;
        wr_d = we_g;
        rdata_d = '0;
        abort_d = 1'b0;
      end
      REQ: state_d = lmmi_ready ? (wr_q ? ACK : RDWAIT) : (timeout ? ERR : REQ);
      RDWAIT: begin
        rdata_d = lmmi_rdata_valid ? lmmi_rdata : rdata_q;
        state_d = lmmi_rdata_valid ? ACK : (timeout ? ERR : RDWAIT);
      end
      default: begin
        last_d = grant_q;
        state_d = IDLE;
      end
    endcase
  end
  // A requester that dropped cyc during its transfer gets neither ack nor err.
  always_comb begin
    wb_ack = '0;
    wb_err = '0;
    wb_dat_r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wb_ack[i] = state_q == ACK && grant_q == GW'(i) && !abort_q && wb_cyc[i];
`ifdef LMMI_ARB_TIMEOUT_EN
      wb_err[i] = state_q == ERR && grant_q == GW'(i) && !abort_q && wb_cyc[i];
`endif
      wb_dat_r[32*i +: 32] = wb_ack[i] ? rdata_q : 32'h0;
    end
  end
`ifdef LMMI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d = ((state_q == REQ || state_q == RDWAIT) && state_d == state_q) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NUM_REQ - 1);
      offset_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      rdata_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      offset_q <= offset_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
    end
endmodule
